// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences the M-stage data-memory access over a req/ack bus
// Ports: MemWriteM/ResultSrcM/funct3M/ALUResultM/WriteDataM from the E|M register;
//   StallM holds the pipeline, ReadDataM is extended load data valid in DONE,
//   MisalignM/BusErrM are 1-cycle error pulses; mem_* is the req/ack data bus.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        r_we;
  logic [3:0]  r_be;
  logic [2:0]  r_f3;
  logic [1:0]  r_lo;
  logic        w_acc, w_mis, w_issue, w_tmo, w_last;
  logic [1:0]  w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_sh, w_ext;
  assign w_acc   = MemWriteM | (ResultSrcM == 2'b01);
  assign w_size  = funct3M[1:0];
  assign w_mis   = (w_size == 2'b01 & ALUResultM[0]) | (w_size[1] & |ALUResultM[1:0]);
  assign w_issue = r_state == IDLE & w_acc & ~w_mis;
  assign w_last  = r_cnt == CW'(TIMEOUT - 1);
  assign w_tmo   = r_state == WAIT & ~mem_ack & w_last;
  assign w_be    = w_size == 2'b00 ? 4'b0001 << ALUResultM[1:0] :
                   w_size == 2'b01 ? 4'b0011 << {ALUResultM[1], 1'b0} : 4'b1111;
  assign w_wdata = w_size == 2'b00 ? {4{WriteDataM[7:0]}} :
                   w_size == 2'b01 ? {2{WriteDataM[15:0]}} : WriteDataM;
  // byte/half lanes are brought down to bit 0 before extension
  assign w_sh    = mem_rdata >> {r_lo, 3'b000};
  assign w_ext   = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & w_sh[7]}}, w_sh[7:0]} :
                   r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & w_sh[15]}}, w_sh[15:0]} : mem_rdata;
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next    = r_state;
    StallM    = 1'b0;
    MisalignM = 1'b0;
    BusErrM   = 1'b0;
    mem_req   = 1'b0;
    if (!reset) begin
      w_next    = r_state == IDLE ? (w_issue ? WAIT : IDLE) :
                  r_state == WAIT ? ((mem_ack | w_tmo) ? DONE : WAIT) : IDLE;
      StallM    = w_issue | r_state == WAIT;
      MisalignM = r_state == IDLE & w_acc & w_mis;
      BusErrM   = w_tmo;
      mem_req   = r_state == WAIT;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_f3    <= '0;
      r_lo    <= '0;
    end else begin
      if (w_issue) begin
        r_addr  <= {ALUResultM[31:2], 2'b00};
        r_we    <= MemWriteM;
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_f3    <= funct3M;
        r_lo    <= ALUResultM[1:0];
        r_cnt   <= '0;
      end
      if (r_state == WAIT) begin
        r_cnt <= w_last ? r_cnt : r_cnt + 1'b1;
        if (mem_ack) r_rdata <= r_we ? '0 : w_ext;
        else if (w_tmo) r_rdata <= '0;
      end
    end
  end
  assign ReadDataM = r_rdata;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed checks of mem_access_ctrl against a lane-arithmetic model
module tb_mem_access_ctrl;
  localparam int T = 16;
  logic        clk = 1'b0, reset = 1'b1, MemWriteM = 1'b0, mem_ack = 1'b0;
  logic [1:0]  ResultSrcM = 2'b00;
  logic [2:0]  funct3M = 3'b000;
  logic [31:0] ALUResultM = '0, WriteDataM = '0, mem_rdata = '0;
  logic        StallM, MisalignM, BusErrM, mem_req, mem_we;
  logic [31:0] ReadDataM, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int tests = 0, fails = 0;

  mem_access_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .ReadDataM(ReadDataM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // one access from issue to return-to-IDLE; d = WAIT cycle carrying the ack (>= T means never)
  task automatic acc(input bit st, input logic [2:0] f3, input logic [31:0] a, wd, rd,
                     input int d, input string nm);
    int size, off, nwait, n, stalls;
    bit mis, eerr;
    logic [3:0] ebe;
    logic [31:0] ewd, erd, mask;
    size  = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    mis   = (a % size) != 0;
    off   = int'(a % 4);
    ebe   = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % size) +: 8];
    erd = rd >> (8 * off);
    if (size < 4) begin
      mask = (32'h1 << (8 * size)) - 1;
      erd  = erd & mask;
      if (!f3[2] && erd[8*size-1]) erd = erd | ~mask;
    end
    if (st || d >= T) erd = '0;
    nwait = d < T ? d + 1 : T;
    MemWriteM = st; ResultSrcM = st ? 2'b00 : 2'b01; funct3M = f3; ALUResultM = a; WriteDataM = wd;
    @(negedge clk);
    stalls = int'(StallM);
    tests++;
    if ({MisalignM, StallM, mem_req} !== {mis, !mis, 1'b0}) begin
      fails++;
      $display("FAIL %s issue {mis,stall,req}: got %b required %b", nm, {MisalignM, StallM, mem_req}, {mis, !mis, 1'b0});
    end
    if (!mis) begin
      @(posedge clk); #1;
      for (n = 0; n < T + 2; n++) begin
        mem_ack   = (n == d);
        mem_rdata = (n == d) ? rd : $urandom;
        eerr      = (n == T - 1) && (d >= T);
        @(negedge clk);
        stalls += int'(StallM);
        tests++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, BusErrM} !== {1'b1, st, ebe, a & ~32'h3, ewd, eerr}) begin
          fails++;
          $display("FAIL %s wait%0d bus: got req=%b we=%b be=%b addr=%h wd=%h err=%b required req=1 we=%b be=%b addr=%h wd=%h err=%b",
                   nm, n, mem_req, mem_we, mem_be, mem_addr, mem_wdata, BusErrM, st, ebe, a & ~32'h3, ewd, eerr);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (n == d || eerr) break;
      end
      @(negedge clk);
      tests++;
      if ({StallM, mem_req, BusErrM, ReadDataM} !== {3'b000, erd}) begin
        fails++;
        $display("FAIL %s done: got stall=%b req=%b err=%b rd=%h required 0 0 0 rd=%h", nm, StallM, mem_req, BusErrM, ReadDataM, erd);
      end
      tests++;
      if (stalls != nwait + 1) begin
        fails++;
        $display("FAIL %s stall_cycles: got %0d required %0d", nm, stalls, nwait + 1);
      end
    end
    MemWriteM = 1'b0; ResultSrcM = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({mem_req, StallM, MisalignM, BusErrM} !== 4'b0000) begin
      fails++;
      $display("FAIL %s idle_after: got %b required 0000", nm, {mem_req, StallM, MisalignM, BusErrM});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({StallM, MisalignM, BusErrM, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadDataM} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got stall=%b req=%b we=%b be=%b addr=%h wd=%h rd=%h required all 0",
               StallM, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadDataM);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    acc(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw");
    acc(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, "lb");
    acc(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 2, "lbu");
    acc(1'b0, 3'b001, 32'h102, 32'h0, 32'h9ABC1234, 1, "lh");
    acc(1'b0, 3'b101, 32'h102, 32'h0, 32'h9ABC1234, 0, "lhu");
    acc(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 1, "sh");
    acc(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0, "sb");
    acc(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, "lw_mis");
    acc(1'b1, 3'b001, 32'h203, 32'h1, 32'h0, 0, "sh_mis");
    acc(1'b0, 3'b010, 32'h104, 32'h0, 32'h5555AAAA, T - 1, "ack_last");
    acc(1'b0, 3'b010, 32'h108, 32'h0, 32'h5555AAAA, T + 4, "timeout");
  endtask

  task automatic test_ack_idle();
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    tests++;
    if ({mem_req, StallM, BusErrM} !== 3'b000) begin
      fails++;
      $display("FAIL ack_idle: got req/stall/err %b required 000", {mem_req, StallM, BusErrM});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h300;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1; ResultSrcM = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    tests++;
    if ({StallM, MisalignM, BusErrM, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadDataM} !== '0) begin
      fails++;
      $display("FAIL reset_mid_wait: got stall=%b req=%b we=%b be=%b addr=%h rd=%h required all 0",
               StallM, mem_req, mem_we, mem_be, mem_addr, ReadDataM);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    tests++;
    if ({StallM, mem_req, ReadDataM} !== '0) begin
      fails++;
      $display("FAIL late_ack: got stall=%b req=%b rd=%h required 0 0 0", StallM, mem_req, ReadDataM);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit st;
    logic [2:0] f3;
    int d;
    for (int k = 0; k < 60; k++) begin
      st = 1'($urandom);
      f3 = st ? {1'b0, 2'($urandom)} : 3'($urandom);
      d  = ($urandom % 8 == 0) ? T + int'($urandom % 3) : int'($urandom % 4);
      acc(st, f3, $urandom, $urandom, $urandom, d, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ack_idle();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
